div_period_meas: RTL

DIV_PERIOD_MEAS -- requirements
Module: div_period_meas

---
 rtl/div_period_meas.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/div_period_meas.sv
// Measures the period, high phase and low phase of a divided clock in reference clk cycles.
// Optional define DIV_PERIOD_MEAS_SYNC_EN adds a 2-flop synchronizer on div_in for asynchronous sources.
module div_period_meas #(
    parameter int CNT_W     = 16,
    parameter int MIN_RATIO = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [CNT_W-1:0] lo_cnt,
    output logic             valid,
    output logic             odd_duty,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;

    // A working counter sitting here would reach all-ones on its next increment.
    localparam logic [CNT_W-1:0] TMO_LIM = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t           state;
    logic             din;
    logic             d_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] hi_w;
    logic [CNT_W-1:0] lo_w;
    logic [CNT_W-1:0] cap_ratio;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

`ifdef DIV_PERIOD_MEAS_SYNC_EN
    logic sync_p0;
    logic sync_p1;

    // Synchronizer stages p0/p1 ahead of the edge-detect register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= div_in;
            sync_p1 <= sync_p0;
        end
    end

    assign din = sync_p1;
`else
    assign din = div_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= din;
        end
    end

    assign rise      = din & ~d_q;
    assign fall      = ~din & d_q;
    assign cap_ratio = sat_add(hi_w, lo_w);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hi_w     <= '0;
            lo_w     <= '0;
            ratio    <= '0;
            hi_cnt   <= '0;
            lo_cnt   <= '0;
            valid    <= 1'b0;
            odd_duty <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!meas_en) begin
                state <= IDLE;
                hi_w  <= '0;
                lo_w  <= '0;
                err   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        hi_w  <= '0;
                        lo_w  <= '0;
                        state <= SYNC;
                    end
                    SYNC: begin
                        if (rise) begin
                            hi_w  <= CNT_W'(1);
                            lo_w  <= '0;
                            state <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            lo_w  <= CNT_W'(1);
                            state <= LOW;
                        end else if (hi_w == TMO_LIM) begin
                            err   <= 1'b1;
                            hi_w  <= '0;
                            lo_w  <= '0;
                            state <= SYNC;
                        end else begin
                            hi_w <= hi_w + 1'b1;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            // Rising edge closes the period: publish and start the next one.
                            ratio    <= cap_ratio;
                            hi_cnt   <= hi_w;
                            lo_cnt   <= lo_w;
                            odd_duty <= (hi_w != lo_w);
                            valid    <= 1'b1;
                            if (cap_ratio < CNT_W'(MIN_RATIO)) begin
                                err <= 1'b1;
                            end
                            hi_w  <= CNT_W'(1);
                            lo_w  <= '0;
                            state <= HIGH;
                        end else if (lo_w == TMO_LIM) begin
                            err   <= 1'b1;
                            hi_w  <= '0;
                            lo_w  <= '0;
                            state <= SYNC;
                        end else begin
                            lo_w <= lo_w + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
